// File: rtl/cpu_pkg.sv
// Shared definitions for the lab CPU instruction side: instruction layout,
// opcode/ALU constants and the issuer state encoding.
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    CHECK,
    BUSY,
    NEXT
  } issuer_state_t;

endpackage

// File: rtl/instr_issuer_if.sv
// Start/waiting handshake between the instruction issuer and the datapath controller.
interface instr_issuer_if;
  import cpu_pkg::*;

  logic [INSTR_W-1:0] instr;
  logic               start;
  logic               waiting;

  modport master (output instr, output start, input waiting);
  modport slave  (input instr, input start, output waiting);

endinterface

// File: rtl/instr_issuer_prog_mem.sv
// Program buffer: one write port, registered read port feeding instr directly.
module prog_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Storage is never cleared; only the read register resets so instr starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_issuer.sv
// Issues buffered instructions to the datapath controller over start/waiting,
// flagging refused instructions and runs that hang past the watchdog limit.
module instr_issuer
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               go,
  input  logic [AW:0]        len,
  instr_issuer_if.master     ctrl,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      pc,
  output logic               err_reject,
  output logic               err_timeout
);

  localparam int WW = $clog2(TIMEOUT + 1);

  issuer_state_t state, state_d;
  logic [AW:0]   len_q;
  logic [AW:0]   issued;
  logic [WW-1:0] wd;
  logic          start_d;
  logic          last;
  logic          wd_expired;

  assign last       = (issued + 1'b1) == len_q;
  assign wd_expired = wd == WW'(TIMEOUT - 1);
  assign busy       = state != IDLE;

  prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (prog_we && state == IDLE),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (state == LOAD),
    .raddr (pc),
    .rdata (ctrl.instr)
  );

  // The completion check happens on leaving CHECK/BUSY: the final instruction
  // returns straight to IDLE so done lands the cycle after the controller finishes.
  always_comb begin
    state_d = state;
    start_d = 1'b0;
    case (state)
      IDLE:  if (go && len != '0) state_d = LOAD;
      LOAD:  begin
        state_d = ISSUE;
        start_d = ctrl.waiting;
      end
      ISSUE: begin
        if (ctrl.start && ctrl.waiting) state_d = CHECK;
        else                            start_d = ctrl.waiting;
      end
      CHECK: begin
        if (ctrl.waiting) state_d = last ? IDLE : NEXT;
        else              state_d = BUSY;
      end
      BUSY: begin
        if (ctrl.waiting)    state_d = last ? IDLE : NEXT;
        else if (wd_expired) state_d = IDLE;
      end
      NEXT:    state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ctrl.start  <= 1'b0;
      done        <= 1'b0;
      pc          <= '0;
      err_reject  <= 1'b0;
      err_timeout <= 1'b0;
      len_q       <= '0;
      issued      <= '0;
      wd          <= '0;
    end else begin
      state      <= state_d;
      ctrl.start <= start_d;
      done       <= 1'b0;
      case (state)
        IDLE: if (go) begin
          len_q       <= len;
          pc          <= '0;
          issued      <= '0;
          err_reject  <= 1'b0;
          err_timeout <= 1'b0;
          done        <= len == '0;
        end
        CHECK: begin
          wd <= '0;
          if (ctrl.waiting) begin
            err_reject <= 1'b1;
            issued     <= issued + 1'b1;
            done       <= last;
          end
        end
        BUSY: begin
          if (ctrl.waiting) begin
            issued <= issued + 1'b1;
            done   <= last;
          end else if (wd_expired) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        NEXT:    pc <= pc + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: a behavioural controller stub plus a cycle-level
// reference model of issue timing, error flags and register results.
module tb_instr_issuer;
  import cpu_pkg::*;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          go;
  logic [AW:0]   len;
  logic          busy, done, err_reject, err_timeout;
  logic [AW-1:0] pc;

  instr_issuer_if ctrl();

  instr_issuer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .go(go), .len(len), .ctrl(ctrl), .busy(busy),
    .done(done), .pc(pc), .err_reject(err_reject), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller stub: leaves WAIT on a legal start, returns after a planned latency (0 = hang).
  logic [15:0] R [8];
  logic [15:0] ctl_ir;
  logic        ctl_busy;
  int          ctl_cnt;
  int          lat_live[$];

  function automatic bit legal(input logic [15:0] ir);
    return (ir[15:13] == OP_MOV && ir[12:11] == 2'b10) || ir[15:13] == OP_ALU;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl.waiting <= 1'b1;
      ctl_busy     <= 1'b0;
      ctl_cnt      <= 0;
      for (int r = 0; r < 8; r++) R[r] <= '0;
    end else if (!ctl_busy) begin
      if (ctrl.start && legal(ctrl.instr)) begin
        ctrl.waiting <= 1'b0;
        ctl_busy     <= 1'b1;
        ctl_ir       <= ctrl.instr;
        ctl_cnt      <= (lat_live.size() > 0) ? lat_live.pop_front() : 1;
      end
    end else if (ctl_cnt == 1) begin
      ctrl.waiting <= 1'b1;
      ctl_busy     <= 1'b0;
      if (ctl_ir[15:13] == OP_MOV)
        R[ctl_ir[10:8]] <= {{8{ctl_ir[7]}}, ctl_ir[7:0]};
      else case (ctl_ir[12:11])
        ALU_ADD: R[ctl_ir[7:5]] <= R[ctl_ir[10:8]] + R[ctl_ir[2:0]];
        ALU_AND: R[ctl_ir[7:5]] <= R[ctl_ir[10:8]] & R[ctl_ir[2:0]];
        ALU_MVN: R[ctl_ir[7:5]] <= ~R[ctl_ir[2:0]];
        default: ;
      endcase
    end else if (ctl_cnt > 1) begin
      ctl_cnt <= ctl_cnt - 1;
    end
  end

  // Reference model: start offsets follow from controller latency alone.
  logic [15:0] prog [DEPTH];
  logic [15:0] mreg [8];
  int          lat_plan[$];
  string       exp_str;
  int          exp_done, exp_pc;
  bit          exp_rej, exp_to;

  function automatic void predict(input int n);
    int t, li, L;
    logic [15:0] ir;
    exp_str = ""; exp_rej = 0; exp_to = 0; exp_pc = 0; exp_done = 1; t = 2; li = 0;
    for (int r = 0; r < 8; r++) mreg[r] = R[r];
    for (int i = 0; i < n; i++) begin
      ir = prog[i];
      exp_str = {exp_str, $sformatf("%0d,", t)};
      exp_pc = i;
      if (!legal(ir)) begin
        exp_rej = 1;
        exp_done = t + 2;
        t += 4;
      end else begin
        L = lat_plan[li]; li++;
        if (L == 0) begin
          exp_to = 1;
          exp_done = t + 2 + TIMEOUT;
          return;
        end
        if (ir[15:13] == OP_MOV) mreg[ir[10:8]] = {{8{ir[7]}}, ir[7:0]};
        else if (ir[12:11] == ALU_ADD) mreg[ir[7:5]] = mreg[ir[10:8]] + mreg[ir[2:0]];
        else if (ir[12:11] == ALU_AND) mreg[ir[7:5]] = mreg[ir[10:8]] & mreg[ir[2:0]];
        else if (ir[12:11] == ALU_MVN) mreg[ir[7:5]] = ~mreg[ir[2:0]];
        exp_done = t + L + 2;
        t += L + 4;
      end
    end
  endfunction

  // Trace of the last run, indexed by absolute cycle.
  logic        tr_start [int];
  logic [15:0] tr_instr [int];
  int          both;

  function automatic string act_starts(input int g);
    string s = "";
    foreach (tr_start[c]) if (tr_start[c]) s = {s, $sformatf("%0d,", c - g)};
    return s;
  endfunction

  task automatic write_prog(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = AW'(i); prog_data = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run(input int n, input bit we0, input logic [15:0] d0,
                     output int g, output int d_off);
    tr_start.delete(); tr_instr.delete();
    both = 0; d_off = -1;
    @(negedge clk);
    go = 1'b1; len = (AW+1)'(n); g = cyc;
    if (we0) begin
      prog_we = 1'b1; prog_addr = '0; prog_data = d0;
    end
    @(negedge clk);
    go = 1'b0;
    if (we0) prog_we = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tr_start[cyc] = ctrl.start;
      tr_instr[cyc] = ctrl.instr;
      if (done && busy) both++;
      if (done) begin
        d_off = cyc - g;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (d_off < 0) $display("FAIL run_done: no done within 600 cycles (len=%0d)", n);
    else passed++;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; len = '0;
    repeat (3) @(negedge clk);
    total++; if (ctrl.instr !== 16'h0) $display("FAIL rst_instr: got %h want 0", ctrl.instr); else passed++;
    total++; if (ctrl.start !== 1'b0) $display("FAIL rst_start: got %b want 0", ctrl.start); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    total++; if (pc !== '0) $display("FAIL rst_pc: got %0d want 0", pc); else passed++;
    total++; if ({err_reject, err_timeout} !== 2'b00) $display("FAIL rst_err: got %b want 00", {err_reject, err_timeout}); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_mov();
    int g, d;
    prog[0] = 16'hD007; prog[1] = 16'hD105; write_prog(2);
    lat_live = {1, 1};
    run(2, 0, 16'h0, g, d);
    total++; if (act_starts(g) != "2,7,") $display("FAIL mov_starts: got %s want 2,7,", act_starts(g)); else passed++;
    total++; if (d !== 10) $display("FAIL mov_done: got %0d want 10", d); else passed++;
    total++; if ({err_reject, err_timeout} !== 2'b00) $display("FAIL mov_err: got %b want 00", {err_reject, err_timeout}); else passed++;
    total++; if (R[0] !== 16'd7 || R[1] !== 16'd5) $display("FAIL mov_regs: got %0d,%0d want 7,5", R[0], R[1]); else passed++;
    total++; if (both !== 0) $display("FAIL mov_done_busy: got %0d overlap cycles want 0", both); else passed++;
  endtask

  task automatic test_add();
    int g, d;
    prog[2] = 16'hA140; write_prog(3);
    lat_live = {1, 1, 4};
    run(3, 0, 16'h0, g, d);
    total++; if (act_starts(g) != "2,7,12,") $display("FAIL add_starts: got %s want 2,7,12,", act_starts(g)); else passed++;
    total++; if (d !== 18) $display("FAIL add_done: got %0d want 18", d); else passed++;
    for (int c = 13; c <= 16; c++) begin
      total++;
      if (tr_instr[g + c] !== 16'hA140) $display("FAIL add_instr_hold: cycle +%0d got %h want a140", c, tr_instr[g + c]);
      else passed++;
    end
    total++; if (R[2] !== 16'd12) $display("FAIL add_r2: got %0d want 12", R[2]); else passed++;
  endtask

  task automatic test_reject();
    int g, d;
    prog[0] = 16'h0000; prog[1] = 16'hD003; write_prog(2);
    lat_live = {1};
    run(2, 0, 16'h0, g, d);
    total++; if (err_reject !== 1'b1) $display("FAIL rej_flag: got %b want 1", err_reject); else passed++;
    total++; if (act_starts(g) != "2,6,") $display("FAIL rej_starts: got %s want 2,6,", act_starts(g)); else passed++;
    total++; if (d !== 9) $display("FAIL rej_done: got %0d want 9", d); else passed++;
    total++; if (R[0] !== 16'd3) $display("FAIL rej_r0: got %0d want 3", R[0]); else passed++;
  endtask

  task automatic test_timeout();
    int g, d;
    prog[0] = 16'hD001; prog[1] = 16'hD102; prog[2] = 16'hD203; write_prog(3);
    lat_live = {1, 0};
    run(3, 0, 16'h0, g, d);
    total++; if (err_timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", err_timeout); else passed++;
    total++; if (d !== 24) $display("FAIL to_done: got %0d want 24", d); else passed++;
    total++; if (act_starts(g) != "2,7,") $display("FAIL to_starts: got %s want 2,7,", act_starts(g)); else passed++;
    total++; if (pc !== 4'd1) $display("FAIL to_pc: got %0d want 1", pc); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL to_busy: got %b want 0", busy); else passed++;
    pulse_reset();
  endtask

  task automatic test_len_zero();
    int g, d;
    run(0, 0, 16'h0, g, d);
    total++; if (d !== 1) $display("FAIL len0_done: got %0d want 1", d); else passed++;
    total++; if (act_starts(g) != "") $display("FAIL len0_start: got %s want none", act_starts(g)); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int g, d;
    bit found = 0;
    prog[0] = 16'h0000; prog[1] = 16'hD007; prog[2] = 16'hD105; prog[3] = 16'hA140; write_prog(4);
    lat_live = {1, 1, 4};
    @(negedge clk); go = 1'b1; len = 5'd4;
    @(negedge clk); go = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (ctrl.start && ctrl.instr == 16'hA140) found = 1;
    end
    total++; if (!found) $display("FAIL rmid_reach_add: got no ADD start within 100 cycles"); else passed++;
    @(negedge clk); @(negedge clk);
    total++; if (busy !== 1'b1 || err_reject !== 1'b1) $display("FAIL rmid_pre: got busy=%b rej=%b want 1,1", busy, err_reject); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || ctrl.start !== 1'b0) $display("FAIL rmid_async: got busy=%b start=%b want 0,0", busy, ctrl.start); else passed++;
    total++; if (err_reject !== 1'b0 || pc !== '0) $display("FAIL rmid_clear: got rej=%b pc=%0d want 0,0", err_reject, pc); else passed++;
    @(negedge clk); rst = 1'b0;
    prog[0] = 16'hD00B; write_prog(1);
    lat_live = {2};
    run(1, 0, 16'h0, g, d);
    total++; if (tr_instr[g + 2] !== 16'hD00B) $display("FAIL rmid_restart_instr: got %h want d00b", tr_instr[g + 2]); else passed++;
    total++; if (d !== 6 || R[0] !== 16'd11) $display("FAIL rmid_restart: got done=%0d r0=%0d want 6,11", d, R[0]); else passed++;
  endtask

  task automatic test_busy_ignore();
    int g, d;
    prog[0] = 16'hD021; prog[1] = 16'hD122; write_prog(2);
    lat_live = {3, 3};
    fork
      run(2, 0, 16'h0, g, d);
      begin
        repeat (4) @(negedge clk);
        go = 1'b1; len = 5'd9; prog_we = 1'b1; prog_addr = '0; prog_data = 16'h0000;
        @(negedge clk);
        go = 1'b0; prog_we = 1'b0;
      end
    join
    total++; if (act_starts(g) != "2,9,") $display("FAIL busy_go_starts: got %s want 2,9,", act_starts(g)); else passed++;
    total++; if (d !== 14 || R[0] !== 16'h21) $display("FAIL busy_go_done: got done=%0d r0=%h want 14,21", d, R[0]); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL busy_go_idle: got %b want 0", busy); else passed++;
    lat_live = {1};
    run(1, 0, 16'h0, g, d);
    total++; if (tr_instr[g + 2] !== 16'hD021) $display("FAIL busy_we_buffer: got %h want d021", tr_instr[g + 2]); else passed++;
  endtask

  task automatic test_go_write();
    int g, d;
    lat_live = {1};
    run(1, 1, 16'hD0FF, g, d);
    total++; if (tr_instr[g + 2] !== 16'hD0FF) $display("FAIL gowr_instr: got %h want d0ff", tr_instr[g + 2]); else passed++;
    total++; if (R[0] !== 16'hFFFF) $display("FAIL gowr_r0: got %h want ffff", R[0]); else passed++;
  endtask

  task automatic test_random();
    int g, d, n, k;
    bit we0;
    logic [15:0] d0;
    for (int run_i = 0; run_i < 8; run_i++) begin
      for (int i = 0; i < DEPTH; i++) begin
        k = $urandom_range(0, 9);
        if (k < 2)      prog[i] = {3'b000, 13'($urandom)};
        else if (k < 5) prog[i] = {OP_MOV, 2'b10, 3'($urandom), 8'($urandom)};
        else            prog[i] = {OP_ALU, 2'($urandom), 3'($urandom), 3'($urandom), 2'b00, 3'($urandom)};
      end
      write_prog(DEPTH);
      n   = (run_i == 0) ? DEPTH : $urandom_range(1, DEPTH);
      we0 = ($urandom_range(0, 2) == 0);
      d0  = {OP_MOV, 2'b10, 3'($urandom), 8'($urandom)};
      if (we0) prog[0] = d0;
      lat_plan.delete();
      for (int i = 0; i < DEPTH; i++) lat_plan.push_back(($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 6));
      lat_live = lat_plan;
      predict(n);
      run(n, we0, d0, g, d);
      total++; if (act_starts(g) != exp_str) $display("FAIL rnd_starts[%0d]: got %s want %s", run_i, act_starts(g), exp_str); else passed++;
      total++; if (d !== exp_done) $display("FAIL rnd_done[%0d]: got %0d want %0d", run_i, d, exp_done); else passed++;
      total++; if ({err_reject, err_timeout} !== {exp_rej, exp_to}) $display("FAIL rnd_err[%0d]: got %b want %b", run_i, {err_reject, err_timeout}, {exp_rej, exp_to}); else passed++;
      total++; if (pc !== AW'(exp_pc)) $display("FAIL rnd_pc[%0d]: got %0d want %0d", run_i, pc, exp_pc); else passed++;
      total++; if (both !== 0) $display("FAIL rnd_done_busy[%0d]: got %0d overlap want 0", run_i, both); else passed++;
      for (int r = 0; r < 8; r++) begin
        total++;
        if (R[r] !== mreg[r]) $display("FAIL rnd_reg[%0d] R%0d: got %h want %h", run_i, r, R[r], mreg[r]);
        else passed++;
      end
      if (exp_to) pulse_reset();
    end
  endtask

  initial begin
    test_reset();
    test_mov();
    test_add();
    test_reject();
    test_timeout();
    test_len_zero();
    test_reset_mid_run();
    test_busy_ignore();
    test_go_write();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
